extamp_rx: RTL and testbench

UART receiver and Elecraft `FA` command parser for the external-amplifier link. It receives 9600-baud 8N1 bytes, matches the 14-byte frame `FA` + 11 ASCII digits + `;`, and converts the decimal field to a 32-bit binary frequency with a one-cycle valid strobe. It is the consuming stage paired with the band-control transmitter: it gives loopback checking of the transmitted command and accepts frequency reports from an amplifier or tuner on the same link.

---
 rtl/extamp_rx.sv | 211 +++++++++++++++++++++
 tb/tb_extamp_rx.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/extamp_rx.sv
// UART receiver (8N1) and "FA" + 11 digits + ";" frequency parser for the external-amplifier link.
// Define EXTAMP_RX_INV_EN for the inverted line (idle low, data inverted).
module extamp_rx #(
  parameter int unsigned CLKFREQ  = 76800000,
  parameter int unsigned BAUDRATE = 9600
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        uart_rxd,
  output logic [31:0] freq,
  output logic        freq_valid,
  output logic        frame_err,
  output logic        cmd_err
);

  localparam int unsigned Div  = CLKFREQ / BAUDRATE;
  localparam int unsigned CntW = $clog2(Div);
  localparam logic [CntW-1:0] CntFull = CntW'(Div - 1);
  localparam logic [CntW-1:0] CntHalf = CntW'(Div / 2 - 1);

`ifdef EXTAMP_RX_INV_EN
  localparam logic LineIdle = 1'b0;
`else
  localparam logic LineIdle = 1'b1;
`endif

  typedef enum logic [1:0] {RxIdle, RxStart, RxData, RxStop} rx_state_e;
  typedef enum logic [1:0] {PIdle, PF, PDig, PSemi} p_state_e;

  logic [1:0]      sync_q;
  logic            rxl;
  rx_state_e       rx_state_q, rx_state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [2:0]      bit_q, bit_d;
  logic [7:0]      shift_q, shift_d;
  logic            cnt_zero, stop_sample;
  logic            byte_stb_q, byte_stb_d, frame_err_q, frame_err_d;

  // Reset the synchronizer to the idle level so release never looks like a start edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= {2{LineIdle}};
    else        sync_q <= {sync_q[0], uart_rxd};
  end

`ifdef EXTAMP_RX_INV_EN
  assign rxl = ~sync_q[1];
`else
  assign rxl = sync_q[1];
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_state_q  <= RxIdle;
      cnt_q       <= '0;
      bit_q       <= '0;
      shift_q     <= '0;
      byte_stb_q  <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      rx_state_q  <= rx_state_d;
      cnt_q       <= cnt_d;
      bit_q       <= bit_d;
      shift_q     <= shift_d;
      byte_stb_q  <= byte_stb_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign cnt_zero = (cnt_q == '0);

  always_comb begin
    rx_state_d = rx_state_q;
    cnt_d      = cnt_zero ? cnt_q : cnt_q - CntW'(1);
    bit_d      = bit_q;
    shift_d    = shift_q;
    unique case (rx_state_q)
      RxIdle: begin
        if (!rxl) begin
          cnt_d      = CntHalf;
          rx_state_d = RxStart;
        end
      end
      RxStart: begin
        if (cnt_zero) begin
          if (rxl) begin
            rx_state_d = RxIdle;
          end else begin
            cnt_d      = CntFull;
            bit_d      = '0;
            rx_state_d = RxData;
          end
        end
      end
      RxData: begin
        if (cnt_zero) begin
          shift_d = {rxl, shift_q[7:1]};
          cnt_d   = CntFull;
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) rx_state_d = RxStop;
        end
      end
      RxStop: begin
        if (cnt_zero) rx_state_d = RxIdle;
      end
      default: rx_state_d = RxIdle;
    endcase
  end

  always_comb begin
    stop_sample = (rx_state_q == RxStop) && cnt_zero;
    byte_stb_d  = stop_sample && rxl;
    frame_err_d = stop_sample && !rxl;
  end

  p_state_e    p_state_q, p_state_d, resync_state;
  logic [31:0] acc_q, acc_d, digit;
  logic [3:0]  n_q, n_d;
  logic        ovf_q, ovf_d;
  logic [31:0] freq_q, freq_d;
  logic        freq_valid_q, freq_valid_d, cmd_err_q, cmd_err_d;
  logic        is_digit, is_f, is_semi;

  assign is_digit     = (shift_q >= 8'h30) && (shift_q <= 8'h39);
  assign is_f         = (shift_q == 8'h46);
  assign is_semi      = (shift_q == 8'h3B);
  assign digit        = {28'd0, shift_q[3:0]};
  assign resync_state = is_f ? PF : PIdle;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p_state_q    <= PIdle;
      acc_q        <= '0;
      n_q          <= '0;
      ovf_q        <= 1'b0;
      freq_q       <= '0;
      freq_valid_q <= 1'b0;
      cmd_err_q    <= 1'b0;
    end else begin
      p_state_q    <= p_state_d;
      acc_q        <= acc_d;
      n_q          <= n_d;
      ovf_q        <= ovf_d;
      freq_q       <= freq_d;
      freq_valid_q <= freq_valid_d;
      cmd_err_q    <= cmd_err_d;
    end
  end

  always_comb begin
    p_state_d = p_state_q;
    acc_d     = acc_q;
    n_d       = n_q;
    ovf_d     = ovf_q;
    if (frame_err_q) begin
      p_state_d = PIdle;
    end else if (byte_stb_q) begin
      unique case (p_state_q)
        PIdle: if (is_f) p_state_d = PF;
        PF: begin
          if (shift_q == 8'h41) begin
            p_state_d = PDig;
            acc_d     = '0;
            n_d       = '0;
            ovf_d     = 1'b0;
          end else begin
            p_state_d = resync_state;
          end
        end
        PDig: begin
          if (is_digit) begin
            acc_d = (acc_q << 3) + (acc_q << 1) + digit;
            n_d   = n_q + 4'd1;
            // Leading three digits must be zero to stay within 99,999,999.
            if (n_q < 4'd3 && digit != '0) ovf_d = 1'b1;
            if (n_q == 4'd10) p_state_d = PSemi;
          end else begin
            p_state_d = resync_state;
          end
        end
        PSemi:   p_state_d = is_semi ? PIdle : resync_state;
        default: p_state_d = PIdle;
      endcase
    end
  end

  always_comb begin
    freq_d       = freq_q;
    freq_valid_d = 1'b0;
    cmd_err_d    = 1'b0;
    if (byte_stb_q) begin
      unique case (p_state_q)
        PDig: cmd_err_d = !is_digit;
        PSemi: begin
          if (is_semi && !ovf_q) begin
            freq_d       = acc_q;
            freq_valid_d = 1'b1;
          end else begin
            cmd_err_d = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign freq       = freq_q;
  assign freq_valid = freq_valid_q;
  assign cmd_err    = cmd_err_q;
  assign frame_err  = frame_err_q;

endmodule

// File: tb/tb_extamp_rx.sv
// Bench for extamp_rx: directed UART frames, positional frame model and event scoreboard.
// Line polarity follows EXTAMP_RX_INV_EN; the baud rate is raised to keep the run short.
`timescale 1ns/1ps
module tb_extamp_rx;
  localparam int unsigned CLKFREQ  = 76800000;
  localparam int unsigned BAUDRATE = 4800000;
  localparam int unsigned DIV      = CLKFREQ / BAUDRATE;
  localparam int EvValid = 0;
  localparam int EvCmd   = 1;
  localparam int EvFrame = 2;

  typedef struct {
    int          kind;
    logic [31:0] val;
  } ev_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        uart_rxd;
  logic [31:0] freq;
  logic        freq_valid, frame_err, cmd_err;

  int          tests = 0;
  int          fails = 0;
  ev_t         exp_q[$];
  byte unsigned rx_buf[$];
  logic [31:0] cur_freq = '0;

  extamp_rx #(.CLKFREQ(CLKFREQ), .BAUDRATE(BAUDRATE)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .uart_rxd  (uart_rxd),
    .freq      (freq),
    .freq_valid(freq_valid),
    .frame_err (frame_err),
    .cmd_err   (cmd_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: actual %0d required %0d", name, act, req);
    end
  endtask

  function automatic void push_ev(input int kind, input logic [31:0] val);
    ev_t e;
    e.kind = kind;
    e.val  = val;
    exp_q.push_back(e);
  endfunction

  // Frame model: position in "FA" + 11 digits + ";" decides what each byte must be.
  function automatic void model_byte(input byte unsigned b, input bit stop_ok);
    int     pos;
    bit     match;
    bit     ovf;
    longint val;
    if (!stop_ok) begin
      push_ev(EvFrame, '0);
      rx_buf.delete();
      return;
    end
    pos = rx_buf.size();
    if (pos == 0)       match = (b == 8'h46);
    else if (pos == 1)  match = (b == 8'h41);
    else if (pos == 13) match = (b == 8'h3B);
    else                match = (b >= 8'h30) && (b <= 8'h39);
    if (!match) begin
      if (pos >= 2) push_ev(EvCmd, '0);
      rx_buf.delete();
      if (b == 8'h46) rx_buf.push_back(b);
      return;
    end
    rx_buf.push_back(b);
    if (pos == 13) begin
      val = 0;
      ovf = 1'b0;
      for (int i = 2; i < 13; i++) begin
        val = val * 10 + (longint'(rx_buf[i]) - 48);
        if (i < 5 && rx_buf[i] != 8'h30) ovf = 1'b1;
      end
      if (ovf) push_ev(EvCmd, '0);
      else     push_ev(EvValid, val[31:0]);
      rx_buf.delete();
    end
  endfunction

  task automatic set_line(input bit v);
`ifdef EXTAMP_RX_INV_EN
    uart_rxd = ~v;
`else
    uart_rxd = v;
`endif
  endtask

  task automatic bit_time(input bit v);
    set_line(v);
    repeat (DIV) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input byte unsigned b, input bit stop_ok);
    model_byte(b, stop_ok);
    bit_time(1'b0);
    for (int i = 0; i < 8; i++) bit_time(b[i]);
    bit_time(stop_ok);
    check("byte_events_drained", exp_q.size(), 0);
    if (!stop_ok) begin
      set_line(1'b1);
      repeat (2 * DIV) @(posedge clk);
      #1;
    end
  endtask

  task automatic send_str(input string s, input int bad_idx, input int count);
    for (int i = 0; i < count && i < s.len(); i++) send_byte(s[i], i != bad_idx);
  endtask

  always @(negedge clk) begin
    int  npulse;
    int  kind;
    ev_t e;
    if (rst_n) begin
      npulse = int'(freq_valid) + int'(cmd_err) + int'(frame_err);
      check("pulse_overlap", 32'(npulse > 1), 0);
      if (npulse != 0) begin
        kind = freq_valid ? EvValid : (cmd_err ? EvCmd : EvFrame);
        if (exp_q.size() == 0) begin
          check("unexpected_pulse", kind, 99);
        end else begin
          e = exp_q.pop_front();
          check("pulse_kind", kind, e.kind);
          if (e.kind == EvValid) cur_freq = e.val;
        end
      end
      check("freq_track", freq, cur_freq);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: actual timeout required finish");
    $fatal(1, "timeout");
  end

  initial begin
    set_line(1'b1);
    repeat (3) @(posedge clk);
    #1;
    check("rst_freq", freq, 0);
    check("rst_freq_valid", freq_valid, 0);
    check("rst_cmd_err", cmd_err, 0);
    check("rst_frame_err", frame_err, 0);
    rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;

    send_str("FA00007074000;", -1, 14);
    check("nominal_freq", freq, 32'h006BF0D0);

    send_str("FA00014074000;", -1, 14);
    check("b2b_first", freq, 32'd14074000);
    send_str("FA00000475000;", -1, 14);
    check("b2b_second", freq, 32'd475000);

    send_str("FA0000707x", -1, 10);
    send_str("FA00003573000;", -1, 14);
    check("resync_freq", freq, 32'd3573000);

    send_str("FA10000000000;", -1, 14);
    check("out_of_range_hold", freq, 32'd3573000);

    send_str("FA00007074000;", 4, 14);
    check("frame_err_hold", freq, 32'd3573000);
    send_str("FA00001840000;", -1, 14);
    check("after_frame_err", freq, 32'd1840000);

    set_line(1'b0);
    repeat (DIV / 4) @(posedge clk);
    #1;
    set_line(1'b1);
    repeat (3 * DIV) @(posedge clk);
    #1;
    check("glitch_no_event", exp_q.size(), 0);
    check("glitch_hold", freq, 32'd1840000);

    send_str("FA00050313000;", -1, 7);
    rst_n = 1'b0;
    exp_q.delete();
    rx_buf.delete();
    cur_freq = '0;
    #1;
    check("midrst_freq", freq, 0);
    check("midrst_freq_valid", freq_valid, 0);
    check("midrst_cmd_err", cmd_err, 0);
    check("midrst_frame_err", frame_err, 0);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    send_str("FA00050313000;", -1, 14);
    check("post_reset_freq", freq, 32'd50313000);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
